// File: rtl/ibex_xif_mem_arbiter.sv
// Two-host to one-device memory arbiter for the Ibex XIF memory path.
// Round-robin with request hold, split-access lock and in-order response routing.
module ibex_xif_mem_arbiter #(
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int INTG_WIDTH      = 7,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    h0_req_i,
  output logic                    h0_gnt_o,
  input  logic [ADDR_WIDTH-1:0]   h0_addr_i,
  input  logic                    h0_we_i,
  input  logic [DATA_WIDTH/8-1:0] h0_be_i,
  input  logic [DATA_WIDTH-1:0]   h0_wdata_i,
  input  logic [INTG_WIDTH-1:0]   h0_wintg_i,
  input  logic                    h0_misaligned_first_i,
  output logic                    h0_rvalid_o,
  output logic [DATA_WIDTH-1:0]   h0_rdata_o,
  output logic [INTG_WIDTH-1:0]   h0_rintg_o,
  output logic                    h0_err_o,
  input  logic                    h1_req_i,
  output logic                    h1_gnt_o,
  input  logic [ADDR_WIDTH-1:0]   h1_addr_i,
  input  logic                    h1_we_i,
  input  logic [DATA_WIDTH/8-1:0] h1_be_i,
  input  logic [DATA_WIDTH-1:0]   h1_wdata_i,
  input  logic [INTG_WIDTH-1:0]   h1_wintg_i,
  input  logic                    h1_misaligned_first_i,
  output logic                    h1_rvalid_o,
  output logic [DATA_WIDTH-1:0]   h1_rdata_o,
  output logic [INTG_WIDTH-1:0]   h1_rintg_o,
  output logic                    h1_err_o,
  output logic                    dev_req_o,
  input  logic                    dev_gnt_i,
  output logic [ADDR_WIDTH-1:0]   dev_addr_o,
  output logic                    dev_we_o,
  output logic [DATA_WIDTH/8-1:0] dev_be_o,
  output logic [DATA_WIDTH-1:0]   dev_wdata_o,
  output logic [INTG_WIDTH-1:0]   dev_wintg_o,
  input  logic                    dev_rvalid_i,
  input  logic [DATA_WIDTH-1:0]   dev_rdata_i,
  input  logic [INTG_WIDTH-1:0]   dev_rintg_i,
  input  logic                    dev_err_i,
  output logic                    busy_o
);

  localparam int CW = $clog2(MAX_OUTSTANDING + 1);
  localparam int PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

  logic                       r_rr_last;
  logic                       r_hold;
  logic                       r_hold_sel;
  logic                       r_lock;
  logic                       r_lock_sel;
  logic [CW-1:0]              r_count;
  logic [PW-1:0]              r_wptr;
  logic [PW-1:0]              r_rptr;
  logic [MAX_OUTSTANDING-1:0] r_fifo;

  logic w_sel;
  logic w_req;
  logic w_mis;
  logic w_dev_req;
  logic w_gnt;
  logic w_pop;
  logic w_head;

  function automatic logic [PW-1:0] f_inc(input logic [PW-1:0] p);
    return (p == PW'(MAX_OUTSTANDING - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    w_sel = ~r_rr_last;
    if (r_lock)
      w_sel = r_lock_sel;
    else if (r_hold)
      w_sel = r_hold_sel;
    else if (h0_req_i ^ h1_req_i)
      w_sel = h1_req_i;
  end

  assign w_req     = w_sel ? h1_req_i : h0_req_i;
  assign w_mis     = w_sel ? h1_misaligned_first_i
                           : h0_misaligned_first_i;
  assign w_dev_req = rst_ni & w_req
                   & (r_count < CW'(MAX_OUTSTANDING));
  assign w_gnt     = dev_gnt_i & w_dev_req;
  assign w_pop     = rst_ni & dev_rvalid_i & (r_count != '0);
  assign w_head    = r_fifo[r_rptr];

  assign dev_req_o   = w_dev_req;
  assign dev_addr_o  = !rst_ni ? '0 : w_sel ? h1_addr_i  : h0_addr_i;
  assign dev_we_o    = rst_ni & (w_sel ? h1_we_i : h0_we_i);
  assign dev_be_o    = !rst_ni ? '0 : w_sel ? h1_be_i    : h0_be_i;
  assign dev_wdata_o = !rst_ni ? '0 : w_sel ? h1_wdata_i : h0_wdata_i;
  assign dev_wintg_o = !rst_ni ? '0 : w_sel ? h1_wintg_i : h0_wintg_i;

  assign h0_gnt_o    = w_gnt & ~w_sel;
  assign h1_gnt_o    = w_gnt & w_sel;
  assign h0_rvalid_o = w_pop & ~w_head;
  assign h1_rvalid_o = w_pop & w_head;
  assign h0_rdata_o  = rst_ni ? dev_rdata_i : '0;
  assign h1_rdata_o  = rst_ni ? dev_rdata_i : '0;
  assign h0_rintg_o  = rst_ni ? dev_rintg_i : '0;
  assign h1_rintg_o  = rst_ni ? dev_rintg_i : '0;
  assign h0_err_o    = rst_ni & dev_err_i;
  assign h1_err_o    = rst_ni & dev_err_i;
  assign busy_o      = r_count != '0;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rr_last  <= 1'b1;
      r_hold     <= 1'b0;
      r_hold_sel <= 1'b0;
      r_lock     <= 1'b0;
      r_lock_sel <= 1'b0;
      r_count    <= '0;
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_fifo     <= '0;
    end else begin
      if (w_gnt) begin
        r_rr_last      <= w_sel;
        r_fifo[r_wptr] <= w_sel;
        r_wptr         <= f_inc(r_wptr);
      end
      if (w_pop)
        r_rptr <= f_inc(r_rptr);
      case ({w_gnt, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      // keep the device request stable until it is accepted
      if (w_gnt)
        r_hold <= 1'b0;
      else if (w_dev_req) begin
        r_hold     <= 1'b1;
        r_hold_sel <= w_sel;
      end
      if (w_gnt) begin
        if (w_mis) begin
          r_lock     <= 1'b1;
          r_lock_sel <= w_sel;
        end else if (r_lock && (w_sel == r_lock_sel))
          r_lock <= 1'b0;
      end
    end
  end

`ifndef SYNTHESIS
  a_spurious_rvalid: assert property (
    @(posedge clk_i) disable iff (!rst_ni)
    dev_rvalid_i |-> (r_count != '0))
    else $warning("device response with no outstanding request dropped");

  a_h0_stable: assert property (
    @(posedge clk_i) disable iff (!rst_ni)
    (h0_req_i && !h0_gnt_o) |=> (h0_req_i && $stable({h0_addr_i,
      h0_we_i, h0_be_i, h0_wdata_i, h0_wintg_i, h0_misaligned_first_i})))
    else $warning("host 0 changed request before grant");

  a_h1_stable: assert property (
    @(posedge clk_i) disable iff (!rst_ni)
    (h1_req_i && !h1_gnt_o) |=> (h1_req_i && $stable({h1_addr_i,
      h1_we_i, h1_be_i, h1_wdata_i, h1_wintg_i, h1_misaligned_first_i})))
    else $warning("host 1 changed request before grant");
`endif

endmodule

// File: doc/ibex_xif_mem_arbiter.md
Name: ibex_xif_mem_arbiter

Overview:
Two-host to one-device memory arbiter for the Ibex X-interface testbench/RTL memory path. Host 0 is the core LSU, host 1 is the XIF coprocessor memory port. The block shares a single request/grant/rvalid memory port (addr, we, be, wdata, wintg, rdata, rintg, error) between them. It tracks outstanding transactions in order so each response returns to the host that issued it.

Parameters:
ADDR_WIDTH, 32, address width
DATA_WIDTH, 32, data width; byte-enable width is DATA_WIDTH/8
INTG_WIDTH, 7, integrity bits per data word
MAX_OUTSTANDING, 4, depth of in-order response-routing FIFO (>=1)

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
hN_req_i  in  1  host N request (N = 0, 1; all hN_* ports exist for both hosts)
hN_gnt_o  out  1  host N grant
hN_addr_i  in  ADDR_WIDTH  host N address
hN_we_i  in  1  host N write enable
hN_be_i  in  DATA_WIDTH/8  host N byte enables
hN_wdata_i  in  DATA_WIDTH  host N write data
hN_wintg_i  in  INTG_WIDTH  host N write integrity
hN_misaligned_first_i  in  1  current request is first half of a split misaligned access
hN_rvalid_o  out  1  host N response valid
hN_rdata_o  out  DATA_WIDTH  read data, broadcast to both hosts
hN_rintg_o  out  INTG_WIDTH  read integrity, broadcast
hN_err_o  out  1  response error, broadcast
dev_req_o  out  1  device request
dev_gnt_i  in  1  device grant
dev_addr_o  out  ADDR_WIDTH  muxed address
dev_we_o  out  1  muxed write enable
dev_be_o  out  DATA_WIDTH/8  muxed byte enables
dev_wdata_o  out  DATA_WIDTH  muxed write data
dev_wintg_o  out  INTG_WIDTH  muxed write integrity
dev_rvalid_i  in  1  device response valid
dev_rdata_i  in  DATA_WIDTH  device read data
dev_rintg_i  in  INTG_WIDTH  device read integrity
dev_err_i  in  1  device response error
busy_o  out  1  outstanding count != 0

Behaviour:
- Reset: rr_last=1 (host 0 wins the first tie), hold=0, lock=0, count=0, FIFO empty. All outputs are 0 while in reset.
- Request path is combinational, zero added latency. dev_* request fields mux from the selected host, sel.
- dev_req_o = selected host's req & (count < MAX_OUTSTANDING).
- hN_gnt_o = dev_gnt_i & dev_req_o & (sel==N).
- Selection priority, highest first:
  1. lock: sel = lock_sel. The other host is never selected while lock is set.
  2. hold: sel = hold_sel.
  3. Only one host requesting: sel = that host.
  4. Both requesting: sel = !rr_last.
  5. Neither requesting: sel = !rr_last (fields don't-care, dev_req_o=0).
- hold: set when dev_req_o & !dev_gnt_i, capturing hold_sel=sel; cleared on grant. The device therefore sees a stable request until granted.
- Hosts keep req and fields stable until gnt. Violations are flagged by an assertion, not handled.
- On grant: rr_last <= sel; push sel into FIFO.
- lock: on a grant where hsel_misaligned_first_i=1, set lock=1 and lock_sel=sel. Cleared on the next grant to lock_sel with misaligned_first=0 (the second half). Split accesses are never interleaved.
- Response: on dev_rvalid_i with FIFO non-empty, pop head and assert h[head]_rvalid_o in the same cycle (combinational). The other host's rvalid stays 0. Responses are strictly in order.
- Grant and rvalid in the same cycle: push and pop together, count unchanged. Legal when full: dev_req_o is already 0, so no push occurs.
- Full (count==MAX_OUTSTANDING): dev_req_o=0, no grants, no bypass on same-cycle rvalid.
- dev_rvalid_i with FIFO empty: spurious. Ignored (no host rvalid, count stays 0), and an assertion fires.
- count width is $clog2(MAX_OUTSTANDING+1). FIFO pointers wrap modulo MAX_OUTSTANDING.
- Reset mid-operation: all state clears immediately. In-flight device responses arriving after reset hit the empty FIFO and are dropped.

Test Plan:
- Only h0 requests addr 0x1000 read; device grants the same cycle and rvalid 2 cycles later with rdata 0xDEADBEEF -> h0_gnt_o=1 that cycle, h0_rvalid_o=1 with 0xDEADBEEF, h1_rvalid_o=0, count returns to 0.
- h0 and h1 request continuously, device always grants -> grants alternate h0,h1,h0,h1, starting with h0 after reset.
- h1 selected; dev_gnt_i=0 for 3 cycles while h0 raises req -> dev_addr_o stays h1_addr_i for all 3 cycles; h1 granted on cycle 4, then h0.
- MAX_OUTSTANDING=4: 4 grants with no rvalid -> dev_req_o=0 on the 5th attempt; one rvalid -> the request proceeds next cycle. Same-cycle grant+rvalid keeps count at 3.
- h0 issues misaligned_first=1 at 0x1003, h1 requesting throughout -> h1 not granted until h0's second half (0x1004, misaligned_first=0) is granted.
- Assert rst_ni=0 with 2 outstanding, release, then device returns 2 rvalids -> no hN_rvalid_o pulses, busy_o=0, spurious-response assertion fires.
